// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
// Shared types and helpers for the reorder buffer.
//   rob_entry_t     : one ROB slot {valid, ready, areg, data}
//   ROB_ENTRY_CLEAR : value of an empty slot
//   clog2()         : tag width for a given entry count
//   AREG_NONE       : architectural index meaning "no destination"
// Entry field widths are fixed here; rob_unit defaults its DATA_W/AREG_W to
// them, so an instance must not use wider DATA_W/AREG_W than these.
// -----------------------------------------------------------------------------
package rob_pkg;

    localparam int ROB_AREG_W = 4;
    localparam int ROB_DATA_W = 32;
    localparam int AREG_NONE  = 0;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic [ROB_AREG_W-1:0] areg;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

    localparam rob_entry_t ROB_ENTRY_CLEAR = '{
        valid: 1'b0,
        ready: 1'b0,
        areg:  {ROB_AREG_W{1'b0}},
        data:  {ROB_DATA_W{1'b0}}
    };

    // Ceiling log2, used for tag widths (clog2(8) = 3, clog2(2) = 1).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rob_lookup.sv
// -----------------------------------------------------------------------------
// rob_lookup
// Rename lookup for one source operand. Finds the youngest valid entry whose
// destination matches areg, scanning from head towards tail, and forwards a
// same-cycle CDB write-back to that entry.
// Ports:
//   entries          : full entry array of the reorder buffer
//   head             : oldest entry pointer
//   areg             : operand architectural register (0 never hits)
//   wb_valid/tag/data: CDB write-back ports, packed per port
//   hit/tag/ready/data : lookup result; tag/ready/data are 0 on a miss
// -----------------------------------------------------------------------------
import rob_pkg::*;

module rob_lookup #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int AREG_W = 4,
    parameter int NWB    = 3,
    parameter int TAG_W  = 3
) (
    input  rob_entry_t              entries [DEPTH],
    input  logic [TAG_W-1:0]        head,
    input  logic [AREG_W-1:0]       areg,
    input  logic [NWB-1:0]          wb_valid,
    input  logic [NWB*TAG_W-1:0]    wb_tag,
    input  logic [NWB*DATA_W-1:0]   wb_data,
    output logic                    hit,
    output logic [TAG_W-1:0]        tag,
    output logic                    ready,
    output logic [DATA_W-1:0]       data
);

    logic             match_hit_s;
    logic [TAG_W-1:0] match_idx_s;
    logic [TAG_W-1:0] pos_s;

    // Youngest-match search: walk oldest to youngest, later matches overwrite
    // earlier ones so the last hit is the youngest in-flight producer.
    always_comb begin
        match_hit_s = 1'b0;
        match_idx_s = {TAG_W{1'b0}};
        pos_s       = head;
        for (int k = 0; k < DEPTH; k++) begin
            pos_s = head + TAG_W'(k);
            if (entries[pos_s].valid &&
                (areg != AREG_W'(AREG_NONE)) &&
                (AREG_W'(entries[pos_s].areg) == areg)) begin
                match_hit_s = 1'b1;
                match_idx_s = pos_s;
            end else begin
                match_hit_s = match_hit_s;
            end
        end
    end

    // Result assembly with CDB forwarding; ports scanned high to low so the
    // lowest-index port matching the hit tag wins. A result already captured
    // in the entry is final (later write-backs to it are ignored), so only a
    // not-yet-ready entry takes forwarded data.
    always_comb begin
        hit   = match_hit_s;
        tag   = match_idx_s;
        ready = match_hit_s && entries[match_idx_s].ready;
        data  = ready ? DATA_W'(entries[match_idx_s].data) : {DATA_W{1'b0}};
        for (int i = NWB - 1; i >= 0; i--) begin
            if (match_hit_s && !entries[match_idx_s].ready && wb_valid[i] &&
                (wb_tag[i*TAG_W +: TAG_W] == match_idx_s)) begin
                ready = 1'b1;
                data  = wb_data[i*DATA_W +: DATA_W];
            end else begin
                ready = ready;
            end
        end
    end

endmodule

// File: rtl/rob_unit.sv
// -----------------------------------------------------------------------------
// rob_unit
// Reorder buffer: in-order tag allocation at dispatch, out-of-order result
// capture from NWB CDB ports, in-order retirement to the ARF through a
// ready/valid commit handshake, two combinational rename lookups and a
// full-pipeline flush.
// Ports:
//   clk1, rst (sync, active-high), flush
//   disp_valid/disp_dest -> disp_ready (= !full), disp_tag (= tail)
//   src1_areg/src2_areg  -> srcN_hit/tag/ready/data
//   wb_valid/wb_tag/wb_data : packed CDB write-back ports
//   commit_valid/areg/data/tag -> ARF, commit_ready <- ARF
//   count, empty, full : occupancy
// -----------------------------------------------------------------------------
import rob_pkg::*;

module rob_unit #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = ROB_DATA_W,
    parameter int AREG_W = ROB_AREG_W,
    parameter int NWB    = 3,
    localparam int TAG_W = clog2(DEPTH)
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  disp_valid,
    input  logic [AREG_W-1:0]     disp_dest,
    output logic                  disp_ready,
    output logic [TAG_W-1:0]      disp_tag,
    input  logic [AREG_W-1:0]     src1_areg,
    output logic                  src1_hit,
    output logic [TAG_W-1:0]      src1_tag,
    output logic                  src1_ready,
    output logic [DATA_W-1:0]     src1_data,
    input  logic [AREG_W-1:0]     src2_areg,
    output logic                  src2_hit,
    output logic [TAG_W-1:0]      src2_tag,
    output logic                  src2_ready,
    output logic [DATA_W-1:0]     src2_data,
    input  logic [NWB-1:0]        wb_valid,
    input  logic [NWB*TAG_W-1:0]  wb_tag,
    input  logic [NWB*DATA_W-1:0] wb_data,
    output logic                  commit_valid,
    input  logic                  commit_ready,
    output logic [AREG_W-1:0]     commit_areg,
    output logic [DATA_W-1:0]     commit_data,
    output logic [TAG_W-1:0]      commit_tag,
    output logic [TAG_W:0]        count,
    output logic                  empty,
    output logic                  full
);

    rob_entry_t       entries_r     [DEPTH];
    rob_entry_t       entries_nxt_s [DEPTH];
    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [TAG_W:0]   count_r;
    logic [TAG_W-1:0] head_nxt_s;
    logic [TAG_W-1:0] tail_nxt_s;
    logic [TAG_W:0]   count_nxt_s;
    logic [TAG_W-1:0] wb_idx_s;
    logic             full_s;
    logic             empty_s;
    logic             commit_valid_s;
    logic             disp_fire_s;
    logic             commit_fire_s;

    // Occupancy flags and handshakes; all derived from registered state only,
    // so there is no commit_ready -> disp_ready and no wb -> commit path.
    always_comb begin
        full_s         = (count_r == (TAG_W+1)'(DEPTH));
        empty_s        = (count_r == {(TAG_W+1){1'b0}});
        commit_valid_s = entries_r[head_r].valid && entries_r[head_r].ready;
        disp_fire_s    = disp_valid && !full_s;
        commit_fire_s  = commit_valid_s && commit_ready;
    end

    // Next-state for entries and pointers. Write-back checks the registered
    // entry, so a port scan from high to low lets the lowest port win. A
    // write-back can never collide with dispatch (tail is invalid unless full)
    // or with commit (a committing head is already ready).
    always_comb begin
        entries_nxt_s = entries_r;
        wb_idx_s      = {TAG_W{1'b0}};
        for (int i = NWB - 1; i >= 0; i--) begin
            wb_idx_s = wb_tag[i*TAG_W +: TAG_W];
            if (wb_valid[i] && entries_r[wb_idx_s].valid && !entries_r[wb_idx_s].ready) begin
                entries_nxt_s[wb_idx_s].ready = 1'b1;
                entries_nxt_s[wb_idx_s].data  = ROB_DATA_W'(wb_data[i*DATA_W +: DATA_W]);
            end else begin
                entries_nxt_s[wb_idx_s] = entries_nxt_s[wb_idx_s];
            end
        end
        if (commit_fire_s) begin
            entries_nxt_s[head_r] = ROB_ENTRY_CLEAR;
        end else begin
            entries_nxt_s[head_r] = entries_nxt_s[head_r];
        end
        if (disp_fire_s) begin
            entries_nxt_s[tail_r] = '{valid: 1'b1,
                                      ready: 1'b0,
                                      areg:  ROB_AREG_W'(disp_dest),
                                      data:  {ROB_DATA_W{1'b0}}};
        end else begin
            entries_nxt_s[tail_r] = entries_nxt_s[tail_r];
        end
        head_nxt_s = commit_fire_s ? (head_r + TAG_W'(1)) : head_r;
        tail_nxt_s = disp_fire_s   ? (tail_r + TAG_W'(1)) : tail_r;
        case ({disp_fire_s, commit_fire_s})
            2'b10:   count_nxt_s = count_r + (TAG_W+1)'(1);
            2'b01:   count_nxt_s = count_r - (TAG_W+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // State registers: reset and flush both empty the buffer and drop any
    // dispatch/write-back/commit presented in the same cycle.
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= ROB_ENTRY_CLEAR;
            end
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {(TAG_W+1){1'b0}};
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= ROB_ENTRY_CLEAR;
            end
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {(TAG_W+1){1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= entries_nxt_s[i];
            end
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Output mapping; commit fields read as zero while nothing can retire.
    always_comb begin
        disp_ready   = !full_s;
        disp_tag     = tail_r;
        commit_valid = commit_valid_s;
        commit_areg  = commit_valid_s ? AREG_W'(entries_r[head_r].areg) : {AREG_W{1'b0}};
        commit_data  = commit_valid_s ? DATA_W'(entries_r[head_r].data) : {DATA_W{1'b0}};
        commit_tag   = head_r;
        count        = count_r;
        empty        = empty_s;
        full         = full_s;
    end

    rob_lookup #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AREG_W (AREG_W),
        .NWB    (NWB),
        .TAG_W  (TAG_W)
    ) u_lookup_src1 (
        .entries  (entries_r),
        .head     (head_r),
        .areg     (src1_areg),
        .wb_valid (wb_valid),
        .wb_tag   (wb_tag),
        .wb_data  (wb_data),
        .hit      (src1_hit),
        .tag      (src1_tag),
        .ready    (src1_ready),
        .data     (src1_data)
    );

    rob_lookup #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AREG_W (AREG_W),
        .NWB    (NWB),
        .TAG_W  (TAG_W)
    ) u_lookup_src2 (
        .entries  (entries_r),
        .head     (head_r),
        .areg     (src2_areg),
        .wb_valid (wb_valid),
        .wb_tag   (wb_tag),
        .wb_data  (wb_data),
        .hit      (src2_hit),
        .tag      (src2_tag),
        .ready    (src2_ready),
        .data     (src2_data)
    );

endmodule

// File: tb/tb_rob_unit.sv
// -----------------------------------------------------------------------------
// tb_rob_unit
// Directed bench for rob_unit (DEPTH=8, DATA_W=32, AREG_W=4, NWB=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// further unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_rob_unit;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int AREG_W = 4;
    localparam int NWB    = 3;
    localparam int TAG_W  = 3;

    logic                  clk1;
    logic                  rst;
    logic                  flush;
    logic                  disp_valid;
    logic [AREG_W-1:0]     disp_dest;
    logic                  disp_ready;
    logic [TAG_W-1:0]      disp_tag;
    logic [AREG_W-1:0]     src1_areg;
    logic                  src1_hit;
    logic [TAG_W-1:0]      src1_tag;
    logic                  src1_ready;
    logic [DATA_W-1:0]     src1_data;
    logic [AREG_W-1:0]     src2_areg;
    logic                  src2_hit;
    logic [TAG_W-1:0]      src2_tag;
    logic                  src2_ready;
    logic [DATA_W-1:0]     src2_data;
    logic [NWB-1:0]        wb_valid;
    logic [NWB*TAG_W-1:0]  wb_tag;
    logic [NWB*DATA_W-1:0] wb_data;
    logic                  commit_valid;
    logic                  commit_ready;
    logic [AREG_W-1:0]     commit_areg;
    logic [DATA_W-1:0]     commit_data;
    logic [TAG_W-1:0]      commit_tag;
    logic [TAG_W:0]        count;
    logic                  empty;
    logic                  full;

    int n_checks = 0;
    int n_errors = 0;

    rob_unit #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AREG_W (AREG_W),
        .NWB    (NWB)
    ) dut (
        .clk1         (clk1),
        .rst          (rst),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_dest    (disp_dest),
        .disp_ready   (disp_ready),
        .disp_tag     (disp_tag),
        .src1_areg    (src1_areg),
        .src1_hit     (src1_hit),
        .src1_tag     (src1_tag),
        .src1_ready   (src1_ready),
        .src1_data    (src1_data),
        .src2_areg    (src2_areg),
        .src2_hit     (src2_hit),
        .src2_tag     (src2_tag),
        .src2_ready   (src2_ready),
        .src2_data    (src2_data),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_areg  (commit_areg),
        .commit_data  (commit_data),
        .commit_tag   (commit_tag),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic wb_set(input int p, input int t, input int d);
        wb_valid[p]                 = 1'b1;
        wb_tag[p*TAG_W +: TAG_W]    = TAG_W'(t);
        wb_data[p*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic wb_clear();
        wb_valid = '0;
        wb_tag   = '0;
        wb_data  = '0;
    endtask

    // One dispatch: check the offered tag, then take the edge.
    task automatic disp(input int dest, input int exp_tag, input string nm);
        disp_valid = 1'b1;
        disp_dest  = AREG_W'(dest);
        #1;
        check_val(nm, 64'(disp_tag), 64'(exp_tag));
        tick();
        disp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_dest = '0;
        src1_areg = '0; src2_areg = '0; commit_ready = 1'b0;
        wb_clear();
        tick(); tick();
        rst = 1'b0;
        src1_areg = 4'd1; src2_areg = 4'd2;
        #1;
        check_val("rst_count",  64'(count), 64'd0);
        check_val("rst_empty",  64'(empty), 64'd1);
        check_val("rst_full",   64'(full), 64'd0);
        check_val("rst_dready", 64'(disp_ready), 64'd1);
        check_val("rst_dtag",   64'(disp_tag), 64'd0);
        check_val("rst_cvalid", 64'(commit_valid), 64'd0);
        check_val("rst_careg",  64'(commit_areg), 64'd0);
        check_val("rst_cdata",  64'(commit_data), 64'd0);
        check_val("rst_s1hit",  64'(src1_hit), 64'd0);
        check_val("rst_s2tag",  64'(src2_tag), 64'd0);

        // In-order allocation
        disp(1, 0, "disp_t0");
        disp(2, 1, "disp_t1");
        disp(3, 2, "disp_t2");
        src1_areg = 4'd2; src2_areg = 4'd3;
        #1;
        check_val("cnt3",      64'(count), 64'd3);
        check_val("empty0",    64'(empty), 64'd0);
        check_val("s1_hit",    64'(src1_hit), 64'd1);
        check_val("s1_tag",    64'(src1_tag), 64'd1);
        check_val("s1_rdy0",   64'(src1_ready), 64'd0);
        check_val("s1_data0",  64'(src1_data), 64'd0);
        check_val("s2_tag",    64'(src2_tag), 64'd2);

        // Same-cycle forwarding, then stored result
        wb_set(1, 1, 16);
        #1;
        check_val("fwd_rdy",   64'(src1_ready), 64'd1);
        check_val("fwd_data",  64'(src1_data), 64'd16);
        tick(); wb_clear(); #1;
        check_val("st_rdy",    64'(src1_ready), 64'd1);
        check_val("st_data",   64'(src1_data), 64'd16);
        check_val("cv_nohead", 64'(commit_valid), 64'd0);

        // Write-back to head: commit_valid only after the edge
        wb_set(0, 0, 12); commit_ready = 1'b1;
        #1;
        check_val("cv_nocomb", 64'(commit_valid), 64'd0);
        tick(); wb_clear(); #1;
        check_val("c0_valid",  64'(commit_valid), 64'd1);
        check_val("c0_areg",   64'(commit_areg), 64'd1);
        check_val("c0_data",   64'(commit_data), 64'd12);
        check_val("c0_tag",    64'(commit_tag), 64'd0);
        tick(); #1;
        check_val("c1_valid",  64'(commit_valid), 64'd1);
        check_val("c1_areg",   64'(commit_areg), 64'd2);
        check_val("c1_data",   64'(commit_data), 64'd16);
        check_val("c1_tag",    64'(commit_tag), 64'd1);
        tick(); commit_ready = 1'b0; #1;
        check_val("c_stall",   64'(commit_valid), 64'd0);
        check_val("cnt1",      64'(count), 64'd1);
        check_val("retired_miss", 64'(src1_hit), 64'd0);

        // Fill to 8 with wrap (head=2, tail=3)
        for (int k = 0; k < 7; k++) begin
            disp(6 + k, (3 + k) % 8, "fill_tag");
        end
        #1;
        check_val("full_cnt",  64'(count), 64'd8);
        check_val("full_flag", 64'(full), 64'd1);
        check_val("full_drdy", 64'(disp_ready), 64'd0);
        check_val("full_dtag", 64'(disp_tag), 64'd2);
        wb_set(2, 2, 99);
        tick(); wb_clear(); #1;
        check_val("h2_valid",  64'(commit_valid), 64'd1);
        check_val("h2_areg",   64'(commit_areg), 64'd3);
        check_val("h2_data",   64'(commit_data), 64'd99);
        commit_ready = 1'b1; disp_valid = 1'b1; disp_dest = 4'd13;
        #1;
        check_val("full_commit_drdy", 64'(disp_ready), 64'd0);
        tick(); commit_ready = 1'b0; #1;
        check_val("after_c_cnt",  64'(count), 64'd7);
        check_val("after_c_drdy", 64'(disp_ready), 64'd1);
        check_val("reuse_tag",    64'(disp_tag), 64'd2);
        tick(); disp_valid = 1'b0; src1_areg = 4'd13; #1;
        check_val("refill_cnt",   64'(count), 64'd8);
        check_val("refill_full",  64'(full), 64'd1);
        check_val("reuse_lkp",    64'(src1_tag), 64'd2);

        // Simultaneous dispatch and commit leaves count unchanged
        wb_set(0, 3, 33);
        tick(); wb_clear(); commit_ready = 1'b1;
        tick(); commit_ready = 1'b0; wb_set(1, 4, 44);
        tick(); wb_clear();
        commit_ready = 1'b1; disp_valid = 1'b1; disp_dest = 4'd14;
        #1;
        check_val("sim_dtag",   64'(disp_tag), 64'd3);
        check_val("sim_cdata",  64'(commit_data), 64'd44);
        tick(); commit_ready = 1'b0; disp_valid = 1'b0; #1;
        check_val("sim_cnt",    64'(count), 64'd7);
        check_val("sim_cv",     64'(commit_valid), 64'd0);

        // Flush with dispatch and commit in the same cycle
        wb_set(0, 5, 55);
        tick(); wb_clear(); #1;
        check_val("pre_fl_cv",  64'(commit_valid), 64'd1);
        flush = 1'b1; commit_ready = 1'b1; disp_valid = 1'b1; disp_dest = 4'd15;
        tick(); flush = 1'b0; commit_ready = 1'b0; disp_valid = 1'b0; #1;
        check_val("fl_cnt",     64'(count), 64'd0);
        check_val("fl_empty",   64'(empty), 64'd1);
        check_val("fl_cv",      64'(commit_valid), 64'd0);
        check_val("fl_dtag",    64'(disp_tag), 64'd0);
        check_val("fl_ctag",    64'(commit_tag), 64'd0);
        check_val("fl_lkp",     64'(src1_hit), 64'd0);

        // Youngest match and lowest-port priority
        disp(5, 0, "dup_t0");
        disp(5, 1, "dup_t1");
        src1_areg = 4'd5; src2_areg = 4'd5;
        #1;
        check_val("young_tag",  64'(src1_tag), 64'd1);
        check_val("young_rdy",  64'(src1_ready), 64'd0);
        wb_set(0, 1, 45); wb_set(2, 1, 3); wb_set(1, 0, 7);
        #1;
        check_val("prio_fwd",   64'(src1_data), 64'd45);
        tick(); wb_clear(); #1;
        check_val("prio_tag2",  64'(src2_tag), 64'd1);
        check_val("prio_rdy2",  64'(src2_ready), 64'd1);
        check_val("prio_data2", 64'(src2_data), 64'd45);
        wb_set(0, 1, 77);
        #1;
        check_val("late_wb_fwd", 64'(src1_data), 64'd45);
        tick(); wb_clear(); #1;
        check_val("late_wb_st", 64'(src1_data), 64'd45);
        check_val("d0_areg",    64'(commit_areg), 64'd5);
        check_val("d0_data",    64'(commit_data), 64'd7);
        commit_ready = 1'b1;
        tick(); #1;
        check_val("d1_data",    64'(commit_data), 64'd45);
        check_val("d1_tag",     64'(commit_tag), 64'd1);
        tick(); commit_ready = 1'b0; #1;
        check_val("drain_empty", 64'(empty), 64'd1);
        check_val("drain_cv",   64'(commit_valid), 64'd0);

        // Destination 0: never renamed, still commits
        disp(0, 2, "z_tag");
        src1_areg = 4'd0;
        #1;
        check_val("z_nohit",    64'(src1_hit), 64'd0);
        wb_set(0, 2, 5);
        tick(); wb_clear(); #1;
        check_val("z_cv",       64'(commit_valid), 64'd1);
        check_val("z_areg",     64'(commit_areg), 64'd0);
        check_val("z_data",     64'(commit_data), 64'd5);
        commit_ready = 1'b1;
        tick(); commit_ready = 1'b0; #1;
        check_val("z_empty",    64'(empty), 64'd1);

        // Reset mid-operation
        disp(4, 3, "r_t3");
        disp(4, 4, "r_t4");
        src1_areg = 4'd4;
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        check_val("mr_cnt",     64'(count), 64'd0);
        check_val("mr_empty",   64'(empty), 64'd1);
        check_val("mr_dtag",    64'(disp_tag), 64'd0);
        check_val("mr_lkp",     64'(src1_hit), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
